// File: rtl/hsv_stream_ctrl_pkg.sv
// Shared image types for the HSV stream path: sequencer states, result pixel
// layout, in-flight tag layout and the fixed latency of the RGB->HSV core.
package hsv_stream_ctrl_pkg;

    localparam int HSV_CORE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } hsv_state_e;

    typedef struct packed {
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
        logic       sof;
        logic       eol;
    } hsv_pix_t;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
    } hsv_tag_t;

endpackage

// File: rtl/hsv_stream_ctrl_if.sv
// Ready/valid stream bundles: RGB pixels into the controller, HSV results out.
interface rgb_stream_if;
    logic       In_Valid;
    logic       In_Ready;
    logic       In_Sof;
    logic [7:0] In_R;
    logic [7:0] In_G;
    logic [7:0] In_B;

    modport master (output In_Valid, In_Sof, In_R, In_G, In_B, input In_Ready);
    modport slave  (input In_Valid, In_Sof, In_R, In_G, In_B, output In_Ready);
endinterface

interface hsv_stream_if;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [8:0] Out_H;
    logic [7:0] Out_S;
    logic [7:0] Out_V;
    logic       Out_Sof;
    logic       Out_Eol;

    modport master (output Out_Valid, Out_H, Out_S, Out_V, Out_Sof, Out_Eol, input Out_Ready);
    modport slave  (input Out_Valid, Out_H, Out_S, Out_V, Out_Sof, Out_Eol, output Out_Ready);
endinterface

// File: rtl/hsv_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead output stage; count covers
// both the storage array and the output register.
module hsv_sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic                   clk_Image_Process,
    input  logic                   Rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      mem_cnt;
    logic             load;

    assign load  = (mem_cnt != '0) && (!rd_valid || rd_en);
    assign count = mem_cnt + {{AW{1'b0}}, rd_valid};
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk_Image_Process) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    // array -> output register stage
    always_ff @(posedge clk_Image_Process) begin
        if (!Rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (load) begin
                rptr     <= rptr + 1'b1;
                rd_data  <= mem[rptr];
                rd_valid <= 1'b1;
            end else if (rd_en) begin
                rd_valid <= 1'b0;
            end
            case ({wr_en, load})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end
endmodule

// File: rtl/hsv_stream_ctrl.sv
// Frame sequencer and credit-based flow control around the fixed-latency,
// non-stalling RGB->HSV core; results land in an output FIFO.
module hsv_stream_ctrl
    import hsv_stream_ctrl_pkg::*;
#(
    parameter int CORE_LAT   = HSV_CORE_LAT,
    parameter int FIFO_DEPTH = 8,
    parameter int DIM_W      = 12
) (
    input  logic             clk_Image_Process,
    input  logic             Rst,
    input  logic [DIM_W-1:0] Frame_Width,
    input  logic [DIM_W-1:0] Frame_Height,
    rgb_stream_if.slave      pix_in,
    hsv_stream_if.master     pix_out,
    output logic [7:0]       Core_R,
    output logic [7:0]       Core_G,
    output logic [7:0]       Core_B,
    input  logic [8:0]       Core_H,
    input  logic [7:0]       Core_S,
    input  logic [7:0]       Core_V,
    output logic             Frame_Done,
    output logic             Sync_Err
);
    localparam int               OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    hsv_state_e       state;
    logic [DIM_W-1:0] w_lat, h_lat, col, row;
    logic [DIM_W-1:0] w_cur, h_cur, col_cur, row_cur;
    logic [OCC_W-1:0] occ, fifo_cnt;
    hsv_tag_t         tag_p [CORE_LAT];
    hsv_pix_t         fifo_d, fifo_q;
    logic             in_hs, new_frame, acc, eol, last, out_hs, tags_busy;
    logic             fifo_wr, fifo_full, fifo_empty, fifo_vld, sync_err_q;

    assign Core_R = pix_in.In_R;
    assign Core_G = pix_in.In_G;
    assign Core_B = pix_in.In_B;

    // occ is registered, so In_Ready never sees Out_Ready combinationally
    assign pix_in.In_Ready = (state != ST_DRAIN) && (occ < OCC_MAX);

    always_comb begin
        in_hs     = pix_in.In_Valid & pix_in.In_Ready;
        new_frame = in_hs & pix_in.In_Sof;
        acc       = new_frame | (in_hs & (state == ST_RUN));
        w_cur     = new_frame ? Frame_Width  : w_lat;
        h_cur     = new_frame ? Frame_Height : h_lat;
        col_cur   = new_frame ? '0 : col;
        row_cur   = new_frame ? '0 : row;
        eol       = (col_cur == w_cur - DIM_ONE);
        last      = eol && (row_cur == h_cur - DIM_ONE);
        tags_busy = 1'b0;
        for (int i = 0; i < CORE_LAT; i++) tags_busy = tags_busy | tag_p[i].vld;
    end

    assign out_hs     = fifo_vld & pix_out.Out_Ready;
    assign Frame_Done = (state == ST_DRAIN) && out_hs && (fifo_cnt == OCC_ONE) && !tags_busy;
    assign Sync_Err   = sync_err_q;

    // stage p0..p(CORE_LAT-1): tags ride alongside the core pipeline
    always_ff @(posedge clk_Image_Process) begin
        if (!Rst) begin
            state      <= ST_IDLE;
            w_lat      <= '0;
            h_lat      <= '0;
            col        <= '0;
            row        <= '0;
            occ        <= '0;
            sync_err_q <= 1'b0;
            for (int i = 0; i < CORE_LAT; i++) tag_p[i] <= '0;
        end else begin
            sync_err_q <= new_frame && (state == ST_RUN);
            tag_p[0]   <= '{vld: acc, sof: new_frame, eol: acc & eol};
            for (int i = 1; i < CORE_LAT; i++) tag_p[i] <= tag_p[i-1];
            case ({acc, out_hs})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
            if (acc) begin
                w_lat <= w_cur;
                h_lat <= h_cur;
                if (eol) begin
                    col <= '0;
                    row <= row_cur + DIM_ONE;
                end else begin
                    col <= col_cur + DIM_ONE;
                    row <= row_cur;
                end
                state <= last ? ST_DRAIN : ST_RUN;
            end else if (state == ST_DRAIN && (Frame_Done || (fifo_empty && !tags_busy))) begin
                state <= ST_IDLE;
            end
        end
    end

    // last tag stage -> FIFO write
    assign fifo_wr = tag_p[CORE_LAT-1].vld;
    always_comb begin
        fifo_d = '{h: Core_H, s: Core_S, v: Core_V,
                   sof: tag_p[CORE_LAT-1].sof, eol: tag_p[CORE_LAT-1].eol};
    end

    hsv_sync_fifo #(
        .WIDTH ($bits(hsv_pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_Image_Process (clk_Image_Process),
        .Rst               (Rst),
        .wr_en             (fifo_wr),
        .wr_data           (fifo_d),
        .rd_en             (out_hs),
        .rd_data           (fifo_q),
        .rd_valid          (fifo_vld),
        .count             (fifo_cnt),
        .full              (fifo_full),
        .empty             (fifo_empty)
    );

    assign pix_out.Out_Valid = fifo_vld;
    assign pix_out.Out_H     = fifo_q.h;
    assign pix_out.Out_S     = fifo_q.s;
    assign pix_out.Out_V     = fifo_q.v;
    assign pix_out.Out_Sof   = fifo_q.sof;
    assign pix_out.Out_Eol   = fifo_q.eol;

    a_no_overflow: assert property (@(posedge clk_Image_Process) disable iff (!Rst)
        !(fifo_wr && fifo_full));
endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// Directed bench for hsv_stream_ctrl with a behavioural 3-cycle HSV core and a
// frame-tracking scoreboard of expected result pixels.
module tb_hsv_stream_ctrl;
    logic        clk_Image_Process = 1'b0;
    logic        Rst;
    logic [11:0] frame_w, frame_h;
    logic [7:0]  Core_R, Core_G, Core_B;
    logic [8:0]  Core_H;
    logic [7:0]  Core_S, Core_V;
    logic        Frame_Done, Sync_Err;

    rgb_stream_if pin ();
    hsv_stream_if pout ();

    hsv_stream_ctrl dut (
        .clk_Image_Process (clk_Image_Process),
        .Rst               (Rst),
        .Frame_Width       (frame_w),
        .Frame_Height      (frame_h),
        .pix_in            (pin),
        .pix_out           (pout),
        .Core_R            (Core_R),
        .Core_G            (Core_G),
        .Core_B            (Core_B),
        .Core_H            (Core_H),
        .Core_S            (Core_S),
        .Core_V            (Core_V),
        .Frame_Done        (Frame_Done),
        .Sync_Err          (Sync_Err)
    );

    always #5 clk_Image_Process = ~clk_Image_Process;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] hsv_of(input logic [7:0] r8, g8, b8);
        int r, g, b, mx, mn, d, h, s;
        r = r8; g = g8; b = b8;
        mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
        d  = mx - mn;
        if (d == 0)       h = 0;
        else if (mx == r) begin h = 60 * (g - b) / d; if (h < 0) h += 360; end
        else if (mx == g) h = 120 + 60 * (b - r) / d;
        else              h = 240 + 60 * (r - g) / d;
        s = (mx == 0) ? 0 : 255 * d / mx;
        return {9'(h), 8'(s), 8'(mx)};
    endfunction

    // Behavioural core: free-running, result three edges after input
    logic [24:0] core_p0, core_p1, core_p2;
    always @(posedge clk_Image_Process) begin
        core_p0 <= hsv_of(Core_R, Core_G, Core_B);
        core_p1 <= core_p0;
        core_p2 <= core_p1;
    end
    assign {Core_H, Core_S, Core_V} = core_p2;

    typedef struct packed {
        logic [8:0] h; logic [7:0] s; logic [7:0] v;
        logic sof; logic eol; logic last;
    } exp_t;

    exp_t        exp_q[$];
    logic [26:0] log_q[$];
    logic [26:0] cur_out, held;
    logic        stall_prev = 1'b0, sync_pend = 1'b0, in_frame = 1'b0;
    int          fw, fh, col, row;
    int          ncyc = 0, acc_cnt = 0, out_cnt = 0, fd_cnt = 0, se_cnt = 0;
    logic        lat_arm = 1'b0;
    int          lat_acc_n = -1, lat_val_n = -1;
    int          max_gap = 0;

    // Scoreboard and output checker, sampled mid-cycle
    always @(negedge clk_Image_Process) begin
        exp_t e;
        ncyc++;
        cur_out = {pout.Out_H, pout.Out_S, pout.Out_V, pout.Out_Sof, pout.Out_Eol};
        if (!Rst) begin
            exp_q.delete();
            in_frame   = 1'b0;
            sync_pend  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("sync_err", Sync_Err, sync_pend);
            sync_pend = 1'b0;
            if (Sync_Err) se_cnt++;
            if (Frame_Done) fd_cnt++;
            if (stall_prev) chk("out_hold", cur_out, held);
            if (lat_arm && lat_val_n < 0 && pout.Out_Valid) lat_val_n = ncyc;
            if (pout.Out_Valid && pout.Out_Ready) begin
                out_cnt++;
                log_q.push_back(cur_out);
                if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_h", pout.Out_H, e.h);
                    chk("out_s", pout.Out_S, e.s);
                    chk("out_v", pout.Out_V, e.v);
                    chk("out_sof", pout.Out_Sof, e.sof);
                    chk("out_eol", pout.Out_Eol, e.eol);
                    chk("frame_done", Frame_Done, e.last);
                end
            end else begin
                chk("frame_done_idle", Frame_Done, 0);
            end
            stall_prev = pout.Out_Valid && !pout.Out_Ready;
            held       = cur_out;
            if (pin.In_Valid && pin.In_Ready) begin
                if (pin.In_Sof) begin
                    if (in_frame) sync_pend = 1'b1;
                    fw = frame_w; fh = frame_h; col = 0; row = 0;
                    in_frame = 1'b1;
                end
                if (in_frame) begin
                    {e.h, e.s, e.v} = hsv_of(pin.In_R, pin.In_G, pin.In_B);
                    e.sof  = pin.In_Sof;
                    e.eol  = (col == fw - 1);
                    e.last = e.eol && (row == fh - 1);
                    exp_q.push_back(e);
                    acc_cnt++;
                    if (lat_arm && lat_acc_n < 0) lat_acc_n = ncyc;
                    if (e.eol) begin col = 0; row++; end else col++;
                    if (e.last) in_frame = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_Image_Process); #1; end
    endtask

    task automatic send_pix(input logic [7:0] r, g, b, input logic sof);
        int   n;
        logic got;
        pin.In_R = r; pin.In_G = g; pin.In_B = b;
        pin.In_Sof = sof; pin.In_Valid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk_Image_Process);
            got = pin.In_Ready;
            @(posedge clk_Image_Process); #1;
            n++;
        end
        pin.In_Valid = 1'b0; pin.In_Sof = 1'b0;
        chk("send_accepted", got, 1);
        if (max_gap > 0) tick($urandom_range(0, max_gap));
    endtask

    task automatic send_frame(input int w, input int h, input int seed);
        logic [7:0] r, g, b;
        frame_w = 12'(w); frame_h = 12'(h);
        for (int i = 0; i < w * h; i++) begin
            if (seed == 0) begin
                case (i % 4)
                    0:       begin r = 8'd255; g = 8'd0;   b = 8'd0;   end
                    1:       begin r = 8'd0;   g = 8'd255; b = 8'd0;   end
                    2:       begin r = 8'd0;   g = 8'd0;   b = 8'd255; end
                    default: begin r = 8'd128; g = 8'd128; b = 8'd128; end
                endcase
            end else begin
                r = 8'($urandom_range(0, 255));
                g = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            send_pix(r, g, b, i == 0);
            // Dimension inputs wander mid-frame; the latched values must rule
            if (i == 0) begin frame_w = 12'(w + 3); frame_h = 12'(h + 1); end
        end
        frame_w = 12'(w); frame_h = 12'(h);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pout.Out_Valid) && n < 1000) begin tick(1); n++; end
        chk(tag, n < 1000, 1);
        tick(2);
    endtask

    int          base_out, base_fd, base_se, base_acc;
    logic [26:0] lg;
    int          exp_h[4] = '{0, 120, 240, 0};
    int          exp_s[4] = '{255, 255, 255, 0};
    int          exp_v[4] = '{255, 255, 255, 128};
    logic        rnd_done;

    initial begin
        Rst = 1'b0;
        pin.In_Valid = 1'b0; pin.In_Sof = 1'b0;
        pin.In_R = 8'd0; pin.In_G = 8'd0; pin.In_B = 8'd0;
        pout.Out_Ready = 1'b1;
        frame_w = 12'd4; frame_h = 12'd2;

        // Reset state
        tick(3);
        chk("rst_out_valid", pout.Out_Valid, 0);
        chk("rst_frame_done", Frame_Done, 0);
        chk("rst_sync_err", Sync_Err, 0);
        chk("rst_out_data", {pout.Out_H, pout.Out_S, pout.Out_V, pout.Out_Sof, pout.Out_Eol}, 0);
        chk("rst_in_ready", pin.In_Ready, 1);
        Rst = 1'b1;
        tick(2);

        // 4x2 frame of primaries and grey, free-flowing output
        base_fd = fd_cnt; log_q.delete();
        lat_arm = 1'b1; lat_acc_n = -1; lat_val_n = -1;
        send_frame(4, 2, 0);
        wait_drain("t1_drain");
        lat_arm = 1'b0;
        // Handshake seen half a cycle before edge t, Out_Valid half a cycle after edge t+4
        chk("t1_latency", lat_val_n - lat_acc_n, 5);
        chk("t1_count", log_q.size(), 8);
        for (int i = 0; i < 4; i++) begin
            lg = log_q[i];
            chk("t1_h", lg[26:18], exp_h[i]);
            chk("t1_s", lg[17:10], exp_s[i]);
            chk("t1_v", lg[9:2], exp_v[i]);
        end
        lg = log_q[0]; chk("t1_sof0", lg[1], 1);
        lg = log_q[2]; chk("t1_eol2", lg[0], 0);
        lg = log_q[3]; chk("t1_eol3", lg[0], 1);
        lg = log_q[7]; chk("t1_eol7", lg[0], 1);
        chk("t1_frame_done", fd_cnt - base_fd, 1);

        // Output stalled for 20 cycles while a 4x4 frame streams in
        base_out = out_cnt; base_fd = fd_cnt; base_acc = acc_cnt;
        fork
            send_frame(4, 4, 2);
            begin
                pout.Out_Ready = 1'b0;
                tick(20);
                chk("t2_accepts_stalled", acc_cnt - base_acc, 8);
                chk("t2_in_ready_low", pin.In_Ready, 0);
                pout.Out_Ready = 1'b1;
            end
        join
        wait_drain("t2_drain");
        chk("t2_out_count", out_cnt - base_out, 16);
        chk("t2_frame_done", fd_cnt - base_fd, 1);

        // Beats without SOF while idle are swallowed
        base_out = out_cnt; base_fd = fd_cnt;
        for (int i = 0; i < 5; i++) send_pix(8'(i * 40), 8'd7, 8'd9, 1'b0);
        tick(10);
        chk("t3_no_output", out_cnt - base_out, 0);
        chk("t3_out_valid", pout.Out_Valid, 0);
        send_frame(4, 2, 3);
        wait_drain("t3_drain");
        chk("t3_out_count", out_cnt - base_out, 8);
        chk("t3_frame_done", fd_cnt - base_fd, 1);

        // SOF arrives at pixel 2 of a 4x2 frame
        base_out = out_cnt; base_fd = fd_cnt; base_se = se_cnt;
        frame_w = 12'd4; frame_h = 12'd2;
        send_pix(8'd10, 8'd20, 8'd30, 1'b1);
        send_pix(8'd40, 8'd50, 8'd60, 1'b0);
        send_frame(4, 2, 0);
        wait_drain("t4_drain");
        chk("t4_sync_err", se_cnt - base_se, 1);
        chk("t4_out_count", out_cnt - base_out, 10);
        chk("t4_frame_done", fd_cnt - base_fd, 1);

        // Reset with three pixels in flight
        base_out = out_cnt;
        frame_w = 12'd4; frame_h = 12'd2;
        send_pix(8'd1, 8'd2, 8'd3, 1'b1);
        send_pix(8'd4, 8'd5, 8'd6, 1'b0);
        send_pix(8'd7, 8'd8, 8'd9, 1'b0);
        Rst = 1'b0;
        tick(1);
        chk("t5_out_valid", pout.Out_Valid, 0);
        chk("t5_in_ready", pin.In_Ready, 1);
        chk("t5_occ", dut.occ, 0);
        Rst = 1'b1;
        tick(10);
        chk("t5_no_stale", out_cnt - base_out, 0);
        send_frame(4, 2, 0);
        wait_drain("t5_drain");
        chk("t5_out_count", out_cnt - base_out, 8);

        // Random input gaps and output backpressure over 10x10 frames
        base_out = out_cnt; base_fd = fd_cnt;
        max_gap = 2; rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(10, 10, 4 + f);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    pout.Out_Ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
                pout.Out_Ready = 1'b1;
            end
        join
        max_gap = 0;
        wait_drain("t6_drain");
        chk("t6_out_count", out_cnt - base_out, 300);
        chk("t6_frame_done", fd_cnt - base_fd, 3);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
